// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared width codes, FSM state type and alignment check for the data RAM arbiter
package ram_pkg;

  localparam int RAM_ADDR_W = 29;
  localparam int RAM_DATA_W = 32;

  localparam logic [1:0] RAM_W_BYTE = 2'd0;
  localparam logic [1:0] RAM_W_HALF = 2'd1;
  localparam logic [1:0] RAM_W_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ram_arb_st_t;

  // True when the width code is supported and the address is naturally aligned for it
  function automatic logic ram_access_legal(input logic [1:0] width, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (width)
      RAM_W_BYTE: ok = 1'b1;
      RAM_W_HALF: ok = ~addr_lo[0];
      RAM_W_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ram_rr_arb2.sv
// rtl/ram_rr_arb2.sv - two-request arbiter with one-hot grant; round-robin under RAMARB_ROUND_ROBIN_EN, else port 0 priority
module ram_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

`ifdef RAMARB_ROUND_ROBIN_EN
  logic ptr_q;
  logic ptr_d;

  // Lone requester wins; on contention the port named by the pointer wins
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // After every accept, priority passes to the port that did not win
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && (gnt_o != 2'b00)) begin
      ptr_d = ~gnt_o[1];
    end
  end

  // Pointer register, starts favouring port 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: port 0 always wins, port 1 only when port 0 is silent
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end

  logic unused_fixed;
  assign unused_fixed = clk ^ rst ^ accept_i;
`endif

endmodule

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - two-port sequencer for the data RAM; RAMARB_ROUND_ROBIN_EN selects round-robin arbitration
module data_ram_arbiter
  import ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0Valid_In,
  input  logic [RAM_ADDR_W-1:0] req0Addr_In,
  input  logic [RAM_DATA_W-1:0] req0Data_In,
  input  logic [1:0]            req0Width_In,
  input  logic                  req0IsRead_In,
  output logic                  req0Ready_Out,
  output logic                  resp0Valid_Out,
  output logic [RAM_DATA_W-1:0] resp0Data_Out,
  output logic                  resp0Err_Out,
  input  logic                  req1Valid_In,
  input  logic [RAM_ADDR_W-1:0] req1Addr_In,
  input  logic [RAM_DATA_W-1:0] req1Data_In,
  input  logic [1:0]            req1Width_In,
  input  logic                  req1IsRead_In,
  output logic                  req1Ready_Out,
  output logic                  resp1Valid_Out,
  output logic [RAM_DATA_W-1:0] resp1Data_Out,
  output logic                  resp1Err_Out,
  output logic [RAM_ADDR_W-1:0] ramAddr_Out,
  output logic [RAM_DATA_W-1:0] ramData_Out,
  output logic [1:0]            ramWidth_Out,
  output logic                  ramIsRead_Out,
  output logic                  ramValid_Out,
  input  logic [RAM_DATA_W-1:0] ramData_In,
  input  logic                  ramOK_In
);

  ram_arb_st_t st_q, st_d;

  logic [RAM_ADDR_W-1:0] addr_q, addr_d;
  logic [RAM_DATA_W-1:0] data_q, data_d;
  logic [1:0]            width_q, width_d;
  logic                  isread_q, isread_d;
  logic                  owner_q, owner_d;
  logic                  ram_valid_q, ram_valid_d;
  logic [1:0]            resp_valid_q, resp_valid_d;
  logic [1:0]            resp_err_q, resp_err_d;
  logic [RAM_DATA_W-1:0] resp0_data_q, resp0_data_d;
  logic [RAM_DATA_W-1:0] resp1_data_q, resp1_data_d;

  logic [1:0]            gnt;
  logic                  accept;
  logic                  winner;
  logic [RAM_ADDR_W-1:0] sel_addr;
  logic [RAM_DATA_W-1:0] sel_data;
  logic [1:0]            sel_width;
  logic                  sel_isread;
  logic                  sel_legal;

  assign accept = (st_q == IDLE) && (req0Valid_In || req1Valid_In);

  ram_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({req1Valid_In, req0Valid_In}),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  // Winning request fields and their legality
  always_comb begin
    winner     = gnt[1];
    sel_addr   = winner ? req1Addr_In   : req0Addr_In;
    sel_data   = winner ? req1Data_In   : req0Data_In;
    sel_width  = winner ? req1Width_In  : req0Width_In;
    sel_isread = winner ? req1IsRead_In : req0IsRead_In;
    sel_legal  = ram_access_legal(sel_width, sel_addr[1:0]);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // Next state: illegal requests skip the RAM and go straight to the response
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (accept) st_d = sel_legal ? ISSUE : RESP;
      ISSUE:   st_d = WAIT;
      WAIT:    if (ramOK_In) st_d = RESP;
      RESP:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Outputs: combinational ready, next values for the latched request and registered outputs
  always_comb begin
    req0Ready_Out = (st_q == IDLE) && gnt[0];
    req1Ready_Out = (st_q == IDLE) && gnt[1];
    addr_d        = addr_q;
    data_d        = data_q;
    width_d       = width_q;
    isread_d      = isread_q;
    owner_d       = owner_q;
    ram_valid_d   = (st_d == ISSUE);
    resp_valid_d  = 2'b00;
    resp_err_d    = 2'b00;
    resp0_data_d  = '0;
    resp1_data_d  = '0;
    if (accept) begin
      addr_d   = sel_addr;
      data_d   = sel_data;
      width_d  = sel_width;
      isread_d = sel_isread;
      owner_d  = winner;
      if (!sel_legal) begin
        resp_valid_d[winner] = 1'b1;
        resp_err_d[winner]   = 1'b1;
      end
    end
    if ((st_q == WAIT) && ramOK_In) begin
      resp_valid_d[owner_q] = 1'b1;
      if (isread_q) begin
        if (owner_q) resp1_data_d = ramData_In;
        else         resp0_data_d = ramData_In;
      end
    end
  end

  // Latched request and registered outputs; responses clear themselves after one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      data_q       <= '0;
      width_q      <= '0;
      isread_q     <= 1'b0;
      owner_q      <= 1'b0;
      ram_valid_q  <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_err_q   <= 2'b00;
      resp0_data_q <= '0;
      resp1_data_q <= '0;
    end else begin
      addr_q       <= addr_d;
      data_q       <= data_d;
      width_q      <= width_d;
      isread_q     <= isread_d;
      owner_q      <= owner_d;
      ram_valid_q  <= ram_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp0_data_q <= resp0_data_d;
      resp1_data_q <= resp1_data_d;
    end
  end

  assign ramAddr_Out    = addr_q;
  assign ramData_Out    = data_q;
  assign ramWidth_Out   = width_q;
  assign ramIsRead_Out  = isread_q;
  assign ramValid_Out   = ram_valid_q;
  assign resp0Valid_Out = resp_valid_q[0];
  assign resp1Valid_Out = resp_valid_q[1];
  assign resp0Err_Out   = resp_err_q[0];
  assign resp1Err_Out   = resp_err_q[1];
  assign resp0Data_Out  = resp0_data_q;
  assign resp1Data_Out  = resp1_data_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - directed vector bench for data_ram_arbiter with a behavioural byte RAM
module tb_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0Valid_In, req1Valid_In;
  logic [28:0] req0Addr_In, req1Addr_In;
  logic [31:0] req0Data_In, req1Data_In;
  logic [1:0]  req0Width_In, req1Width_In;
  logic        req0IsRead_In, req1IsRead_In;
  logic        req0Ready_Out, req1Ready_Out;
  logic        resp0Valid_Out, resp1Valid_Out;
  logic [31:0] resp0Data_Out, resp1Data_Out;
  logic        resp0Err_Out, resp1Err_Out;
  logic [28:0] ramAddr_Out;
  logic [31:0] ramData_Out;
  logic [1:0]  ramWidth_Out;
  logic        ramIsRead_Out;
  logic        ramValid_Out;
  logic [31:0] ramData_In;
  logic        ramOK_In;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          port;
    logic [28:0] addr;
    logic [31:0] data;
    logic [1:0]  width;
    logic        is_read;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  data_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0Valid_In(req0Valid_In), .req0Addr_In(req0Addr_In), .req0Data_In(req0Data_In),
    .req0Width_In(req0Width_In), .req0IsRead_In(req0IsRead_In), .req0Ready_Out(req0Ready_Out),
    .resp0Valid_Out(resp0Valid_Out), .resp0Data_Out(resp0Data_Out), .resp0Err_Out(resp0Err_Out),
    .req1Valid_In(req1Valid_In), .req1Addr_In(req1Addr_In), .req1Data_In(req1Data_In),
    .req1Width_In(req1Width_In), .req1IsRead_In(req1IsRead_In), .req1Ready_Out(req1Ready_Out),
    .resp1Valid_Out(resp1Valid_Out), .resp1Data_Out(resp1Data_Out), .resp1Err_Out(resp1Err_Out),
    .ramAddr_Out(ramAddr_Out), .ramData_Out(ramData_Out), .ramWidth_Out(ramWidth_Out),
    .ramIsRead_Out(ramIsRead_Out), .ramValid_Out(ramValid_Out),
    .ramData_In(ramData_In), .ramOK_In(ramOK_In)
  );

  always #5 clk = ~clk;

  // Byte RAM model: completes one cycle after the valid pulse
  bit [7:0] mem [int];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ramOK_In   <= 1'b0;
      ramData_In <= '0;
    end else begin
      ramOK_In <= ramValid_Out;
      if (ramValid_Out) begin
        automatic int a = int'(ramAddr_Out);
        if (ramIsRead_Out) begin
          case (ramWidth_Out)
            2'd0:    ramData_In <= {24'h0, mem[a]};
            2'd1:    ramData_In <= {16'h0, mem[a+1], mem[a]};
            default: ramData_In <= {mem[a+3], mem[a+2], mem[a+1], mem[a]};
          endcase
        end else begin
          mem[a] = ramData_Out[7:0];
          if (ramWidth_Out != 2'd0) mem[a+1] = ramData_Out[15:8];
          if (ramWidth_Out == 2'd2) begin
            mem[a+2] = ramData_Out[23:16];
            mem[a+3] = ramData_Out[31:24];
          end
          ramData_In <= '0;
        end
      end
    end
  end

  // Pulse monitors sampled away from the active edge
  int ram_pulses = 0;
  int ram_run = 0;
  int max_run = 0;
  int resp0_cnt = 0;
  int resp1_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (ramValid_Out) begin
      if (ram_run == 0) ram_pulses++;
      ram_run++;
      if (ram_run > max_run) max_run = ram_run;
    end else begin
      ram_run = 0;
    end
    if (resp0Valid_Out) resp0_cnt++;
    if (resp1Valid_Out) resp1_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  function automatic logic rdy(input int p);
    return (p != 0) ? req1Ready_Out : req0Ready_Out;
  endfunction
  function automatic logic rvalid(input int p);
    return (p != 0) ? resp1Valid_Out : resp0Valid_Out;
  endfunction
  function automatic logic [31:0] rdata(input int p);
    return (p != 0) ? resp1Data_Out : resp0Data_Out;
  endfunction
  function automatic logic rerr(input int p);
    return (p != 0) ? resp1Err_Out : resp0Err_Out;
  endfunction

  task automatic clear_reqs();
    req0Valid_In = 1'b0; req0Addr_In = '0; req0Data_In = '0; req0Width_In = '0; req0IsRead_In = 1'b0;
    req1Valid_In = 1'b0; req1Addr_In = '0; req1Data_In = '0; req1Width_In = '0; req1IsRead_In = 1'b0;
  endtask

  task automatic set_req(input vec_t v);
    if (v.port == 0) begin
      req0Valid_In = 1'b1; req0Addr_In = v.addr; req0Data_In = v.data;
      req0Width_In = v.width; req0IsRead_In = v.is_read;
    end else begin
      req1Valid_In = 1'b1; req1Addr_In = v.addr; req1Data_In = v.data;
      req1Width_In = v.width; req1IsRead_In = v.is_read;
    end
  endtask

  task automatic wait_ready(input int p, output logic seen);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (rdy(p)) begin
        seen = 1'b1;
        break;
      end
      next_cyc();
    end
  endtask

  // Drive one request, then check the RAM side and the response cycle by cycle
  task automatic run_vec(input string tag, input vec_t v);
    logic seen;
    int   pulses0;
    int   other;
    other = (v.port == 0) ? 1 : 0;
    next_cyc();
    set_req(v);
    #1;
    wait_ready(v.port, seen);
    chk({tag, "_accept"}, {31'h0, seen}, 32'h1);
    if (!seen) begin
      clear_reqs();
      return;
    end
    pulses0 = ram_pulses;
    next_cyc();
    clear_reqs();
    if (v.exp_err) begin
      chk({tag, "_resp_valid"}, {31'h0, rvalid(v.port)}, 32'h1);
      chk({tag, "_resp_err"}, {31'h0, rerr(v.port)}, 32'h1);
      chk({tag, "_resp_data"}, rdata(v.port), 32'h0);
      chk({tag, "_other_resp"}, {31'h0, rvalid(other)}, 32'h0);
      next_cyc();
      chk({tag, "_resp_pulse_end"}, {31'h0, rvalid(v.port)}, 32'h0);
      chk({tag, "_no_ram_access"}, ram_pulses - pulses0, 32'h0);
    end else begin
      chk({tag, "_ram_valid"}, {31'h0, ramValid_Out}, 32'h1);
      chk({tag, "_ram_addr"}, {3'h0, ramAddr_Out}, {3'h0, v.addr});
      chk({tag, "_ram_width"}, {30'h0, ramWidth_Out}, {30'h0, v.width});
      chk({tag, "_ram_isread"}, {31'h0, ramIsRead_Out}, {31'h0, v.is_read});
      if (!v.is_read) chk({tag, "_ram_wdata"}, ramData_Out, v.data);
      chk({tag, "_early_resp"}, {31'h0, rvalid(v.port)}, 32'h0);
      next_cyc();
      chk({tag, "_ram_valid_drop"}, {31'h0, ramValid_Out}, 32'h0);
      next_cyc();
      chk({tag, "_resp_valid"}, {31'h0, rvalid(v.port)}, 32'h1);
      chk({tag, "_resp_data"}, rdata(v.port), v.exp_data);
      chk({tag, "_resp_err"}, {31'h0, rerr(v.port)}, 32'h0);
      chk({tag, "_other_resp"}, {31'h0, rvalid(other)}, 32'h0);
      next_cyc();
      chk({tag, "_resp_pulse_end"}, {31'h0, rvalid(v.port)}, 32'h0);
    end
  endtask

  initial begin
    logic seen;
    int   g;
    int   exp_g;
    int   r1_before;
    int   r0_before;
    int   acc_times[$];
    vec_t c0, c1;

    vecs[0]  = '{0, 29'h100, 32'h0000_0000, 2'd2, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[1]  = '{1, 29'h203, 32'h0000_00A5, 2'd0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[2]  = '{1, 29'h203, 32'h0000_0000, 2'd0, 1'b1, 1'b0, 32'h0000_00A5};
    vecs[3]  = '{0, 29'h102, 32'h0000_0000, 2'd2, 1'b1, 1'b1, 32'h0000_0000};
    vecs[4]  = '{0, 29'h001, 32'h0000_0000, 2'd1, 1'b1, 1'b1, 32'h0000_0000};
    vecs[5]  = '{0, 29'h000, 32'h0000_0000, 2'd3, 1'b1, 1'b1, 32'h0000_0000};
    vecs[6]  = '{0, 29'h010, 32'hFFFF_1234, 2'd1, 1'b0, 1'b0, 32'h0000_0000};
    vecs[7]  = '{0, 29'h010, 32'h0000_0000, 2'd1, 1'b1, 1'b0, 32'h0000_1234};
    vecs[8]  = '{1, 29'h020, 32'hCAFE_F00D, 2'd2, 1'b0, 1'b0, 32'h0000_0000};
    vecs[9]  = '{1, 29'h020, 32'h0000_0000, 2'd2, 1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[10] = '{1, 29'h003, 32'h0000_5555, 2'd1, 1'b0, 1'b1, 32'h0000_0000};
    vecs[11] = '{1, 29'h100, 32'h0000_0000, 2'd0, 1'b1, 1'b0, 32'h0000_00EF};

    mem[32'h100] = 8'hEF;
    mem[32'h101] = 8'hBE;
    mem[32'h102] = 8'hAD;
    mem[32'h103] = 8'hDE;

    // Reset state
    rst = 1'b0;
    clear_reqs();
    repeat (3) next_cyc();
    chk("rst_ram_valid", {31'h0, ramValid_Out}, 32'h0);
    chk("rst_resp_valid", {30'h0, resp1Valid_Out, resp0Valid_Out}, 32'h0);
    chk("rst_ready", {30'h0, req1Ready_Out, req0Ready_Out}, 32'h0);
    chk("rst_err", {30'h0, resp1Err_Out, resp0Err_Out}, 32'h0);
    chk("rst_ram_addr", {3'h0, ramAddr_Out}, 32'h0);
    chk("rst_ram_misc", {29'h0, ramWidth_Out, ramIsRead_Out}, 32'h0);
    rst = 1'b1;
    next_cyc();

    // Table of single transactions
    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Contention: both ports hold a request for four transactions
    c0 = '{0, 29'h100, 32'h0, 2'd2, 1'b1, 1'b0, 32'hDEAD_BEEF};
    c1 = '{1, 29'h100, 32'h0, 2'd2, 1'b1, 1'b0, 32'hDEAD_BEEF};
    r1_before = resp1_cnt;
    next_cyc();
    set_req(c0);
    set_req(c1);
    #1;
    for (int i = 0; i < 4; i++) begin
      seen = 1'b0;
      for (int n = 0; n < 12; n++) begin
        if (req0Ready_Out || req1Ready_Out) begin
          seen = 1'b1;
          break;
        end
        next_cyc();
      end
      chk($sformatf("cont%0d_accept", i), {31'h0, seen}, 32'h1);
      chk($sformatf("cont%0d_onehot", i), {31'h0, req0Ready_Out & req1Ready_Out}, 32'h0);
      g = req1Ready_Out ? 1 : 0;
`ifdef RAMARB_ROUND_ROBIN_EN
      exp_g = i % 2;
`else
      exp_g = 0;
`endif
      chk($sformatf("cont%0d_grant", i), g, exp_g);
      repeat (3) next_cyc();
      chk($sformatf("cont%0d_resp_win", i), {31'h0, rvalid(g)}, 32'h1);
      chk($sformatf("cont%0d_resp_lose", i), {31'h0, rvalid(1 - g)}, 32'h0);
      chk($sformatf("cont%0d_data", i), rdata(g), 32'hDEAD_BEEF);
      if (i == 3) clear_reqs();
      next_cyc();
    end
    repeat (3) next_cyc();
`ifdef RAMARB_ROUND_ROBIN_EN
    chk("cont_resp1_count", resp1_cnt - r1_before, 32'd2);
`else
    chk("cont_resp1_count", resp1_cnt - r1_before, 32'd0);
`endif

    // Reset asserted while waiting for the RAM
    r0_before = resp0_cnt;
    set_req(vecs[0]);
    #1;
    wait_ready(0, seen);
    chk("rstop_accept", {31'h0, seen}, 32'h1);
    next_cyc();
    clear_reqs();
    next_cyc();
    rst = 1'b0;
    #1;
    chk("rstop_ram_valid", {31'h0, ramValid_Out}, 32'h0);
    chk("rstop_resp_valid", {30'h0, resp1Valid_Out, resp0Valid_Out}, 32'h0);
    chk("rstop_ram_addr", {3'h0, ramAddr_Out}, 32'h0);
    chk("rstop_ram_misc", {29'h0, ramWidth_Out, ramIsRead_Out}, 32'h0);
    chk("rstop_resp_data", resp0Data_Out | resp1Data_Out, 32'h0);
    repeat (2) next_cyc();
    rst = 1'b1;
    repeat (3) next_cyc();
    chk("rstop_no_resp", resp0_cnt - r0_before, 32'h0);
    run_vec("rstop_after", vecs[0]);

    // Back-to-back: port 0 holds valid continuously
    next_cyc();
    max_run = 0;
    set_req(vecs[0]);
    #1;
    for (int n = 0; n < 20; n++) begin
      if (req0Ready_Out) acc_times.push_back(cyc);
      next_cyc();
    end
    clear_reqs();
    repeat (4) next_cyc();
    chk("b2b_accept_count", acc_times.size(), 32'd5);
    for (int i = 1; i < acc_times.size(); i++) begin
      chk($sformatf("b2b_gap%0d", i), acc_times[i] - acc_times[i-1], 32'd4);
    end
    chk("b2b_ram_pulse_len", max_run, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Two-port arbiter and sequencer in front of the 512 MiB data RAM. It accepts load/store requests from port 0 (LSU) and port 1 (DMA/debug) and grants one at a time. It checks width and alignment, drives the RAM's single-cycle valid pulse, waits for the RAM's registered completion, and returns a one-cycle response to the winning port.

## Interface
Parameters:
- None. Address width is 29, data width is 32, and there are 2 ports; all three are fixed by the RAM.

Ports (`p` = 0 or 1; each port has its own copy):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `req{p}Valid_In` in 1: request present.
- `req{p}Addr_In` in 29: byte address.
- `req{p}Data_In` in 32: write data; low bits used per width.
- `req{p}Width_In` in 2: access width. 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req{p}IsRead_In` in 1: 1 = load, 0 = store.
- `req{p}Ready_Out` out 1: request accepted this cycle.
- `resp{p}Valid_Out` out 1: one-cycle response pulse.
- `resp{p}Data_Out` out 32: read data. 0 for stores and errors.
- `resp{p}Err_Out` out 1: misaligned access or reserved width.
- `ramAddr_Out` out 29: to RAM `addr`.
- `ramData_Out` out 32: to RAM write data.
- `ramWidth_Out` out 2: to RAM width.
- `ramIsRead_Out` out 1: to RAM read/write select.
- `ramValid_Out` out 1: to RAM input-valid.
- `ramData_In` in 32: from RAM read data.
- `ramOK_In` in 1: from RAM operation-OK.

## Operation
- Only one transaction is in flight at a time. A state register `st` sequences it through four states:
  - **IDLE**: if either `req{p}Valid_In` is high, select a winner (see Configuration). Assert `req{w}Ready_Out` combinationally in this same cycle. Latch addr/data/width/isRead/owner.
    - Illegal request (width 3, half with addr[0] = 1, or word with addr[1:0] ≠ 0): go to RESP with err = 1.
    - Otherwise go to ISSUE.
  - **ISSUE**: `ramValid_Out` = 1 for exactly this cycle. RAM address/data/width/isRead outputs are driven from the latched request. Go to WAIT.
  - **WAIT**: hold until `ramOK_In` = 1. On that cycle, capture `ramData_In` if the access is a read; capture 0 if it is a write. Go to RESP.
  - **RESP**: `resp{owner}Valid_Out` = 1 with the registered data and err. The other port's response stays 0. Go to IDLE.
- Illegal requests never touch the RAM: `ramValid_Out` stays 0.
- Read data is passed through unmodified; the LSU does sign/zero extension. Write data is passed through; the RAM uses the low bits.
- The ready for the losing port is 0. The losing requester holds its request and competes again in the next IDLE.
- `req*Ready_Out` is 0 in every state other than IDLE.
- `ramOK_In` arriving outside WAIT is ignored.

## Timing
- Request accepted in cycle T (IDLE):
  - `ramValid_Out` high in T+1.
  - RAM OK in T+2.
  - `resp*Valid_Out` in T+3.
  - Next accept possible in T+4.
- Error path: accept in T, response in T+1, next accept in T+2.
- Sustained throughput: one legal access per 4 cycles.
- All outputs except `req*Ready_Out` are registered.
- Reset values: `st` = IDLE; all `*Valid_Out`, `*Ready_Out`, and `*Err_Out` = 0; all data/addr/width = 0; `ramIsRead_Out` = 0; round-robin pointer = port 0.
- Reset asserted mid-transaction: the arbiter returns to IDLE immediately and no response is issued. A RAM write already issued may still commit.

## Configuration
- `RAMARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - A one-bit pointer gives priority to the port that did not win last.
  - The pointer updates on every accept, including error accepts.
- Not defined: fixed priority. Port 0 always wins when both ports request; port 1 can starve.

## Structure
- Shared package `ram_pkg`:
  - width codes `RAM_W_BYTE` = 0, `RAM_W_HALF` = 1, `RAM_W_WORD` = 2
  - `RAM_ADDR_W` = 29
  - state typedef `ram_arb_st_t` {IDLE, ISSUE, WAIT, RESP}
  - alignment-check function
- One sub-module, `ram_rr_arb2`: 2-request arbiter with a one-hot grant, containing the pointer register. In fixed-priority builds it reduces to port 0 priority.

## Test plan
- **Single load**: port 0 reads word addr 0x100 with RAM data 0xDEADBEEF.
  - Expect ready at T, `ramValid_Out` at T+1 with addr 0x100 and width 2.
  - Expect `resp0Valid_Out` at T+3 with data 0xDEADBEEF and err 0.
- **Store then load**: port 1 writes byte 0xA5 to 0x203, then reads byte 0x203.
  - Store response: data 0, err 0.
  - Load response: low byte 0xA5.
- **Misaligned**: port 0 issues a word at 0x102, then a half at 0x001, then width 3.
  - Expect err = 1 and data 0 at T+1 for each.
  - Expect `ramValid_Out` never asserted.
- **Contention**: both ports hold valid for 4 transactions.
  - With `RAMARB_ROUND_ROBIN_EN`, grants are 0, 1, 0, 1.
  - Without it, grants are 0, 0, 0, 0.
  - `resp1Valid_Out` is asserted only on port 1's own transactions.
- **Reset mid-op**: deassert `rst` during WAIT.
  - Expect all outputs 0 asynchronously and no response pulse.
  - After release, a new request is accepted normally.
- **Back-to-back**: port 0 holds valid continuously.
  - Expect accepts exactly every 4 cycles.
  - Expect no `ramValid_Out` pulse longer than 1 cycle.
